// File: rtl/arbiter_rr_burst.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter_rr_burst
//  Description : Burst-aware round-robin scheduler. A winner holds a
//                registered one-hot grant for a whole burst. The grant is
//                released on the owner's last beat, when the owner drops its
//                request, or when the MAX_BURST beat cap is reached. An
//                optional turnaround gap separates consecutive owners.
//  Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr_burst #(
    parameter int N          = 4,
    parameter int MAX_BURST  = 8,
    parameter int GAP_CYCLES = 0,
    localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           beat,
    input  logic           last,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           forced_release
);

    // Beat counter holds 0..MAX_BURST-1; one spare value keeps it from ever
    // wrapping even at the cap.
    localparam int CW = $clog2(MAX_BURST + 1);
    // Gap counter is a dummy single bit when no turnaround gap is configured.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [1:0]     c_st_idle  = 2'd0;
    localparam logic [1:0]     c_st_busy  = 2'd1;
    localparam logic [1:0]     c_st_gap   = 2'd2;

    localparam logic [CW-1:0]  c_cap_cnt  = CW'(MAX_BURST - 1);
    localparam logic [GW-1:0]  c_gap_load = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDW-1:0] c_last_idx = IDW'(N - 1);
    localparam logic [N-1:0]   c_one_hot0 = {{(N-1){1'b0}}, 1'b1};

    // Registered state
    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_beat_cnt;
    logic [GW-1:0]  r_gap_cnt;
    logic [N-1:0]   r_grant;
    logic           r_grant_valid;
    logic [IDW-1:0] r_grant_id;
    logic           r_forced;

    // Next-state values
    logic [1:0]     w_state_nxt;
    logic [IDW-1:0] w_ptr_nxt;
    logic [CW-1:0]  w_beat_cnt_nxt;
    logic [GW-1:0]  w_gap_cnt_nxt;
    logic [N-1:0]   w_grant_nxt;
    logic           w_grant_valid_nxt;
    logic [IDW-1:0] w_grant_id_nxt;
    logic           w_forced_nxt;

    // Arbitration datapath
    logic [N-1:0]   w_arb_req;
    logic           w_win_found;
    logic [IDW-1:0] w_win_idx;
    logic [N-1:0]   w_win_onehot;
    logic [IDW-1:0] w_ptr_adv;

    // Release conditions
    logic           w_owner_req;
    logic           w_rel_last;
    logic           w_rel_cap;
    logic           w_rel_abort;
    logic           w_release;
    logic           w_forced;

    assign grant          = r_grant;
    assign grant_valid    = r_grant_valid;
    assign grant_id       = r_grant_id;
    assign forced_release = r_forced;

    // While an owner is being released, it must not win its own handover.
    assign w_arb_req = (r_state == c_st_busy) ? (req & ~r_grant) : req;

    // Circular priority search starting at r_ptr; lowest offset wins.
    always_comb begin
        int v_idx;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        v_idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            v_idx = (int'(r_ptr) + off) % N;
            if (w_arb_req[v_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = IDW'(v_idx);
            end
        end
    end

    assign w_win_onehot = c_one_hot0 << w_win_idx;
    assign w_ptr_adv    = (w_win_idx == c_last_idx) ? '0 : w_win_idx + 1'b1;

    assign w_owner_req = |(req & r_grant);
    assign w_rel_last  = beat & last;
    assign w_rel_cap   = beat & (r_beat_cnt == c_cap_cnt);
    assign w_rel_abort = ~w_owner_req;
    assign w_release   = w_rel_last | w_rel_cap | w_rel_abort;
    // Only a release caused purely by the cap is reported as forced.
    assign w_forced    = w_rel_cap & ~w_rel_last & ~w_rel_abort;

    // Next-state and next-output decode for the IDLE/BUSY/GAP controller.
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_beat_cnt_nxt    = r_beat_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_grant_nxt       = r_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_id_nxt    = r_grant_id;
        w_forced_nxt      = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_win_found) begin
                    w_state_nxt       = c_st_busy;
                    w_grant_nxt       = w_win_onehot;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_id_nxt    = w_win_idx;
                    w_ptr_nxt         = w_ptr_adv;
                    w_beat_cnt_nxt    = '0;
                end
            end

            c_st_busy: begin
                if (w_release) begin
                    w_forced_nxt      = w_forced;
                    w_beat_cnt_nxt    = '0;
                    w_grant_nxt       = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_grant_id_nxt    = '0;
                    if (GAP_CYCLES > 0) begin
                        w_state_nxt   = c_st_gap;
                        w_gap_cnt_nxt = c_gap_load;
                    end else if (w_win_found) begin
                        // Direct handover with no bubble cycle.
                        w_state_nxt       = c_st_busy;
                        w_grant_nxt       = w_win_onehot;
                        w_grant_valid_nxt = 1'b1;
                        w_grant_id_nxt    = w_win_idx;
                        w_ptr_nxt         = w_ptr_adv;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end else if (beat) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                end
            end

            c_st_gap: begin
                if (r_gap_cnt == '0) begin
                    if (w_win_found) begin
                        w_state_nxt       = c_st_busy;
                        w_grant_nxt       = w_win_onehot;
                        w_grant_valid_nxt = 1'b1;
                        w_grant_id_nxt    = w_win_idx;
                        w_ptr_nxt         = w_ptr_adv;
                        w_beat_cnt_nxt    = '0;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt       = c_st_idle;
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
                w_grant_id_nxt    = '0;
                w_beat_cnt_nxt    = '0;
                w_gap_cnt_nxt     = '0;
            end
        endcase
    end

    // State and output registers; reset clears the grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_ptr         <= '0;
            r_beat_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_forced      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_forced      <= w_forced_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr_burst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arbiter_rr_burst
//  Description : Self-checking bench for arbiter_rr_burst. Two instances
//                (no gap, and a 2-cycle gap) run against an owner/queue
//                style reference model plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr_burst;

    localparam int TN   = 4;
    localparam int TMAX = 8;
    localparam int TGAP = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [TN-1:0] req_a = '0;
    logic          beat_a = 1'b0;
    logic          last_a = 1'b0;
    logic [TN-1:0] grant_a;
    logic          gv_a;
    logic [1:0]    gid_a;
    logic          fr_a;

    logic [TN-1:0] req_b = '0;
    logic          beat_b = 1'b0;
    logic          last_b = 1'b0;
    logic [TN-1:0] grant_b;
    logic          gv_b;
    logic [1:0]    gid_b;
    logic          fr_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arbiter_rr_burst #(.N(TN), .MAX_BURST(TMAX), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .beat(beat_a), .last(last_a),
        .grant(grant_a), .grant_valid(gv_a), .grant_id(gid_a), .forced_release(fr_a)
    );

    arbiter_rr_burst #(.N(TN), .MAX_BURST(TMAX), .GAP_CYCLES(TGAP)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .beat(beat_b), .last(last_b),
        .grant(grant_b), .grant_valid(gv_b), .grant_id(gid_b), .forced_release(fr_b)
    );

    // Reference model: owner index (-1 = none), next-priority pointer,
    // beats accepted so far, idle cycles still to be shown, forced flag.
    typedef struct packed {
        int   owner;
        int   ptr;
        int   beats;
        int   gap_left;
        logic forced;
    } mst_t;

    mst_t m_a, m_b;

    function automatic mst_t m_reset();
        mst_t s;
        s.owner = -1; s.ptr = 0; s.beats = 0; s.gap_left = 0; s.forced = 1'b0;
        return s;
    endfunction

    function automatic int pick(logic [TN-1:0] r, int p);
        for (int off = 0; off < TN; off++) begin
            int k;
            k = (p + off) % TN;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic mst_t take(mst_t s, int k);
        mst_t n;
        n = s;
        n.owner = k; n.ptr = (k + 1) % TN; n.beats = 0;
        return n;
    endfunction

    function automatic mst_t m_step(mst_t s, logic [TN-1:0] rq, logic bt, logic ls, int gapc);
        mst_t n;
        logic [TN-1:0] masked;
        logic fin, cap, ab;
        int k;
        n = s;
        n.forced = 1'b0;
        if (s.owner >= 0) begin
            fin = bt & ls;
            cap = bt && (s.beats + 1 == TMAX);
            ab  = !rq[s.owner];
            if (fin || cap || ab) begin
                n.forced = cap & !fin & !ab;
                n.owner = -1;
                n.beats = 0;
                if (gapc == 0) begin
                    masked = rq;
                    masked[s.owner] = 1'b0;
                    k = pick(masked, s.ptr);
                    if (k >= 0) n = take(n, k);
                end else begin
                    n.gap_left = gapc;
                end
            end else if (bt) begin
                n.beats = s.beats + 1;
            end
        end else if (s.gap_left > 1) begin
            n.gap_left = s.gap_left - 1;
        end else begin
            n.gap_left = 0;
            k = pick(rq, s.ptr);
            if (k >= 0) n = take(n, k);
        end
        return n;
    endfunction

    function automatic int exp_grant(mst_t s);
        return (s.owner >= 0) ? (1 << s.owner) : 0;
    endfunction

    function automatic int exp_id(mst_t s);
        return (s.owner >= 0) ? s.owner : 0;
    endfunction

    task automatic cmp(string nm, int act, int req_v);
        total++;
        if (act != req_v) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req_v, $time);
        end
    endtask

    // Advance the model on each edge from the inputs the DUTs see.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a = m_reset();
            m_b = m_reset();
        end else begin
            m_a = m_step(m_a, req_a, beat_a, last_a, 0);
            m_b = m_step(m_b, req_b, beat_b, last_b, TGAP);
        end
    end

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        cmp("a.grant", int'(grant_a), exp_grant(m_a));
        cmp("a.grant_valid", int'(gv_a), int'(m_a.owner >= 0));
        cmp("a.grant_id", int'(gid_a), exp_id(m_a));
        cmp("a.forced_release", int'(fr_a), int'(m_a.forced));
        cmp("b.grant", int'(grant_b), exp_grant(m_b));
        cmp("b.grant_valid", int'(gv_b), int'(m_b.owner >= 0));
        cmp("b.grant_id", int'(gid_b), exp_id(m_b));
        cmp("b.forced_release", int'(fr_b), int'(m_b.forced));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        cmp("lit.reset_grant", int'(grant_a), 0);
        cmp("lit.reset_id", int'(gid_a), 0);
        cmp("lit.reset_fr", int'(fr_a), 0);
        rst = 1'b0;
        tick();

        // Basic: single requester, 3-beat burst
        req_a = 4'b0001;
        tick();
        cmp("lit.basic_grant", int'(grant_a), 1);
        cmp("lit.basic_id", int'(gid_a), 0);
        beat_a = 1'b1; last_a = 1'b0;
        tick(); tick();
        cmp("lit.basic_hold", int'(grant_a), 1);
        last_a = 1'b1;
        tick();
        cmp("lit.basic_release", int'(grant_a), 0);
        req_a = 4'b0000; beat_a = 1'b0; last_a = 1'b0;
        tick();

        // Rotation: ptr is now 1, so 0010 wins first, then back-to-back
        req_a = 4'b1111;
        tick();
        cmp("lit.rot0", int'(grant_a), 4'b0010);
        beat_a = 1'b1; last_a = 1'b1;
        tick(); cmp("lit.rot1", int'(grant_a), 4'b0100);
        tick(); cmp("lit.rot2", int'(grant_a), 4'b1000);
        tick(); cmp("lit.rot3", int'(grant_a), 4'b0001);
        tick(); cmp("lit.rot4", int'(grant_a), 4'b0010);
        req_a = 4'b0000; beat_a = 1'b0; last_a = 1'b0;
        tick();
        cmp("lit.rot_idle", int'(grant_a), 0);

        // Forced release at the beat cap (ptr=2: owner 0 wins over 1)
        req_a = 4'b0011;
        tick();
        cmp("lit.cap_first", int'(grant_a), 4'b0001);
        beat_a = 1'b1; last_a = 1'b0;
        for (int i = 0; i < TMAX - 1; i++) tick();
        cmp("lit.cap_before", int'(grant_a), 4'b0001);
        cmp("lit.cap_before_fr", int'(fr_a), 0);
        tick();
        cmp("lit.cap_handover", int'(grant_a), 4'b0010);
        cmp("lit.cap_fr", int'(fr_a), 1);
        beat_a = 1'b0;
        tick();
        cmp("lit.cap_fr_once", int'(fr_a), 0);
        cmp("lit.cap_owner1", int'(grant_a), 4'b0010);
        beat_a = 1'b1; last_a = 1'b1;
        tick();
        cmp("lit.cap_regain0", int'(grant_a), 4'b0001);
        req_a = 4'b0000; beat_a = 1'b0; last_a = 1'b0;
        tick();

        // Abort: owner 2 drops request, pending owner 1 takes over
        req_a = 4'b0100;
        tick();
        cmp("lit.abort_own2", int'(grant_a), 4'b0100);
        beat_a = 1'b1;
        tick(); tick();
        req_a = 4'b0010; beat_a = 1'b0;
        tick();
        cmp("lit.abort_next", int'(grant_a), 4'b0010);
        cmp("lit.abort_fr", int'(fr_a), 0);
        req_a = 4'b0000;
        tick();

        // Gap on instance b: two empty cycles between owners
        req_b = 4'b0101;
        tick();
        cmp("lit.gap_first", int'(grant_b), 4'b0001);
        beat_b = 1'b1; last_b = 1'b1;
        tick();
        cmp("lit.gap_idle1", int'(grant_b), 0);
        beat_b = 1'b0; last_b = 1'b0;
        tick();
        cmp("lit.gap_idle2", int'(grant_b), 0);
        tick();
        cmp("lit.gap_next", int'(grant_b), 4'b0100);

        // Reset mid-burst: grant must drop before the next edge
        req_a = 4'b0100;
        tick();
        cmp("lit.rst_own2", int'(grant_a), 4'b0100);
        beat_a = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1 cmp("lit.rst_async", int'(grant_a), 0);
        cmp("lit.rst_async_valid", int'(gv_a), 0);
        beat_a = 1'b0; req_a = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        cmp("lit.rst_restart", int'(grant_a), 4'b0001);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
